// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART register-command link: command-byte layout,
// register map and the FSM state encodings used by the initiator and its receiver.
package uart_cmd_pkg;

    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned CMD_ADDR_W = 7;

    localparam logic [CMD_ADDR_W-1:0] REG_LOAD   = 7'h00;
    localparam logic [CMD_ADDR_W-1:0] REG_STORE  = 7'h01;
    localparam logic [CMD_ADDR_W-1:0] REG_PTEXT  = 7'h20;
    localparam logic [CMD_ADDR_W-1:0] REG_KEY    = 7'h21;
    localparam logic [CMD_ADDR_W-1:0] REG_TWEAK1 = 7'h22;
    localparam logic [CMD_ADDR_W-1:0] REG_TWEAK2 = 7'h23;
    localparam logic [CMD_ADDR_W-1:0] REG_RAND   = 7'h24;
    localparam logic [CMD_ADDR_W-1:0] REG_CTEXT  = 7'h25;
    localparam logic [CMD_ADDR_W-1:0] REG_START  = 7'h30;
    localparam logic [CMD_ADDR_W-1:0] REG_INC    = 7'h31;

    typedef enum logic [2:0] {
        StIdle,
        StTxCmd,
        StTxData,
        StWaitRsp,
        StRxByte
    } cmd_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

    function automatic logic [7:0] cmd_byte(input logic write, input logic [CMD_ADDR_W-1:0] addr);
        logic [7:0] b;
        b = '0;
        b[CMD_RW_BIT] = write;
        b[CMD_ADDR_W-1:0] = addr;
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_master_if.sv
// Command/response handshake between a host and the UART command initiator.
interface uart_cmd_master_if;
    import uart_cmd_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [CMD_ADDR_W-1:0] cmd_addr;
    logic [7:0]            cmd_wdata;
    logic                  rsp_valid;
    logic [7:0]            rsp_rdata;
    logic                  rsp_timeout;
    logic                  busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, busy
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Single-byte 8N1 receiver: input synchronizer, start detect with mid-bit glitch
// rejection, mid-bit data sampling and stop-bit check.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DIV = 208
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       rxd,
    output logic       active,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] data
);

    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            bit_tick, half_tick;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            st_q       <= RxIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            st_q       <= st_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
        end
    end

    assign bit_tick  = (cnt_q == CNT_W'(DIV - 1));
    assign half_tick = (cnt_q == CNT_W'(HALF - 1));

    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (st_q)
            RxIdle: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    st_d = RxStart;
                end
            end
            RxStart: begin
                if (half_tick) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is already high again at mid-bit was a glitch.
                    st_d  = rxd_sync_q ? RxIdle : RxData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxData: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        st_d = RxStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RxStop: begin
                if (bit_tick) begin
                    cnt_d      = '0;
                    st_d       = RxIdle;
                    byte_valid = rxd_sync_q;
                    frame_err  = !rxd_sync_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: st_d = RxIdle;
        endcase
        if (!enable) begin
            st_d       = RxIdle;
            cnt_d      = '0;
            byte_valid = 1'b0;
            frame_err  = 1'b0;
        end
    end

    assign active = (st_q != RxIdle);
    assign data   = shift_q;

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side initiator for the UART register protocol: serializes one command at a
// time onto uart_txd and, for reads, collects the single response byte.
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int unsigned UART_CLK_FREQ = 24_000_000,
    parameter int unsigned UART_BAUD     = 115_200,
    parameter int unsigned RSP_TIMEOUT   = 40_000
) (
    input  logic               clk,
    input  logic               n_reset,
    uart_cmd_master_if.slave   cmd,
    output logic               uart_txd,
    input  logic               uart_rxd
);

    localparam int unsigned DIV   = UART_CLK_FREQ / UART_BAUD;
    localparam int unsigned DIV_W = $clog2(DIV + 1);
    localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT + 1);

    logic n_rst_meta_q, n_rst;

    cmd_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             write_q, write_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [TMO_W-1:0] wait_q, wait_d, wait_inc;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_timeout_q, rsp_timeout_d;
    logic [7:0]       rdata_q, rdata_d;

    logic       rx_enable, rx_active, rx_byte_valid, rx_frame_err;
    logic [7:0] rx_data;

    // Reset asserts asynchronously but releases synchronously to clk.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            n_rst_meta_q <= 1'b0;
            n_rst        <= 1'b0;
        end else begin
            n_rst_meta_q <= 1'b1;
            n_rst        <= n_rst_meta_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            div_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            txd_q         <= 1'b1;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            wait_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            txd_q         <= txd_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            wait_q        <= wait_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rdata_q       <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        txd_d         = txd_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        wait_d        = wait_q;
        rdata_d       = rdata_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        wait_inc      = (wait_q == TMO_W'(RSP_TIMEOUT)) ? wait_q : wait_q + TMO_W'(1);
        case (state_q)
            StIdle: begin
                txd_d = 1'b1;
                if (cmd.cmd_valid) begin
                    write_d = cmd.cmd_write;
                    wdata_d = cmd.cmd_wdata;
                    shift_d = cmd_byte(cmd.cmd_write, cmd.cmd_addr);
                    txd_d   = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StTxCmd;
                end
            end
            StTxCmd, StTxData: begin
                if (div_q == DIV_W'(DIV - 1)) begin
                    div_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
                        txd_d = 1'b1;
                        if (state_q == StTxCmd && write_q) begin
                            // Data byte follows the command byte with no idle gap.
                            state_d = StTxData;
                            shift_d = wdata_q;
                            txd_d   = 1'b0;
                        end else if (state_q == StTxCmd) begin
                            state_d = StWaitRsp;
                            wait_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        // Shifting in ones makes the tenth bit the stop bit.
                        bit_d   = bit_q + 4'd1;
                        txd_d   = shift_q[0];
                        shift_d = {1'b1, shift_q[7:1]};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            StWaitRsp: begin
                wait_d = wait_inc;
                if (rx_active) begin
                    state_d = StRxByte;
                end else if (wait_q >= TMO_W'(RSP_TIMEOUT - 1)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            StRxByte: begin
                wait_d = wait_inc;
                if (rx_byte_valid) begin
                    rsp_valid_d = 1'b1;
                    rdata_d     = rx_data;
                    state_d     = StIdle;
                end else if (rx_frame_err) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else if (!rx_active) begin
                    state_d = StWaitRsp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_enable = (state_q == StWaitRsp) || (state_q == StRxByte);

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (rx_enable),
        .rxd        (uart_rxd),
        .active     (rx_active),
        .byte_valid (rx_byte_valid),
        .frame_err  (rx_frame_err),
        .data       (rx_data)
    );

    assign uart_txd        = txd_q;
    assign cmd.cmd_ready   = (state_q == StIdle);
    assign cmd.busy        = (state_q != StIdle);
    assign cmd.rsp_valid   = rsp_valid_q;
    assign cmd.rsp_timeout = rsp_timeout_q;
    assign cmd.rsp_rdata   = rdata_q;

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
- Host-side initiator for the board's UART register protocol. It drives the command link that the on-board UART register interface decodes into addr/wdata/write.
- Accepts one register command at a time (7-bit address, write or read) over a valid/ready handshake.
- Serializes each command onto uart_txd. For reads, captures the single response byte from uart_rxd.
- Used in the system-level bench and in a controller FPGA that drives the SKINNY capture board. Typical use: load plaintext/key/tweak/random, then start, then read back ciphertext.

Parameters:
- UART_CLK_FREQ, 24_000_000, clk frequency in Hz.
- UART_BAUD, 115_200, line rate in baud.
- RSP_TIMEOUT, 40_000, clk cycles to wait for a read response start bit before giving up.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  7  register address.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: read response captured.
- rsp_rdata  out  8  read data; valid while rsp_valid = 1, held until the next response.
- rsp_timeout  out  1  one-cycle pulse: read aborted on timeout or framing error.
- busy  out  1  command in progress (equals !cmd_ready).
- uart_txd  out  1  serial out, idle high.
- uart_rxd  in  1  serial in, asynchronous to clk.

Behaviour:
- Reset is asynchronous on assertion. The design uses it internally through a 2-FF synchronizer for deassertion.
- Reset values:
  - uart_txd = 1, cmd_ready = 1, busy = 0.
  - rsp_valid = 0, rsp_timeout = 0, rsp_rdata = 0x00.
  - FSM in IDLE; all counters 0.
- Bit period: DIV = UART_CLK_FREQ/UART_BAUD, integer division (208 at defaults).
- Frame format: 8N1, LSB first, 10*DIV cycles per byte.
- Command encoding:
  - Byte 0 = {cmd_write, cmd_addr}.
  - Write: byte 1 = cmd_wdata; no response expected.
  - Read: no byte 1; the responder returns exactly one byte.
- Handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - Fields are latched on acceptance; cmd_ready drops the next cycle.
  - cmd_valid while busy is ignored; no queueing.
- FSM:
  - IDLE: on accept -> TX_CMD; the start bit drives low the cycle after accept.
  - TX_CMD: after the stop bit completes -> TX_DATA if write, else WAIT_RSP.
  - TX_DATA: after the stop bit -> IDLE.
  - WAIT_RSP:
    - rx start detected -> RX_BYTE.
    - Wait counter reaches RSP_TIMEOUT -> pulse rsp_timeout, go to IDLE.
  - RX_BYTE:
    - Valid stop bit -> pulse rsp_valid, load rsp_rdata, go to IDLE.
    - Stop bit sampled 0 (framing error) -> pulse rsp_timeout, go to IDLE.
- cmd_ready returns to 1 in the same cycle the FSM enters IDLE. A new command may be accepted then, so back-to-back frames have no extra idle bits.
- RX path:
  - uart_rxd passes through a 2-FF synchronizer.
  - Start = falling edge seen in WAIT_RSP.
  - Start is re-checked at DIV/2; if high, treat as a glitch and return to waiting without resetting the timeout counter.
  - Data bits are sampled every DIV cycles from that midpoint.
  - rxd activity outside WAIT_RSP is ignored.
- The timeout counter starts when WAIT_RSP is entered and saturates; there is no wrap-around.
- rsp_valid and rsp_timeout are mutually exclusive and never assert while cmd_ready = 0.
- Reset mid-frame: uart_txd returns high immediately and the partial frame is abandoned. The responder must resync via its own framing.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - Command-byte layout: RW bit 7, ADDR 6:0.
  - Register address constants LOAD 0x00, STORE 0x01, PTEXT 0x20, KEY 0x21, TWEAK1 0x22, TWEAK2 0x23, RAND 0x24, CTEXT 0x25, START 0x30, INC 0x31.
  - FSM state enum.
- One natural sub-module, uart_rx_byte: synchronizer, start detect, mid-bit sampling, stop check.
  - Outputs: byte_valid, frame_err, data.
  - Enabled only in WAIT_RSP.
- The TX serializer stays inline.

Test Plan:
- Write addr 0x21, data 0xA5 -> txd frames 0xA1 then 0xA5, each 2080 cycles; cmd_ready low for 4160 cycles after accept; no rsp pulse.
- Read addr 0x25, bench responder returns 0x3C 500 cycles after the stop bit -> one frame 0x25; rsp_valid single-cycle pulse with rsp_rdata = 0x3C; cmd_ready high the same cycle.
- Read addr 0x20 with no response -> rsp_timeout pulses exactly RSP_TIMEOUT cycles after entering WAIT_RSP; rsp_valid never asserts.
- Read response with stop bit forced 0 -> rsp_timeout pulses; rsp_rdata retains its previous value.
- 100-cycle low glitch on rxd during WAIT_RSP, then a valid 0x7E frame -> glitch rejected; rsp_rdata = 0x7E.
- Assert n_reset at bit 4 of a write frame -> txd = 1 within the same cycle; after release, cmd_ready = 1 and a new write of 0x30 frames correctly.
